// File: rtl/axis_fifo_rd_stage.sv
// ---------------------------------------------------------------------------
// axis_fifo_rd_stage
// Read-side output stage of the AXI-stream FIFO. It requests words from the
// read pointer and captures the RAM read data one cycle later. A 2-entry
// output buffer (head/tail) feeds the AXI-stream master port. A word in
// flight is always pushed, so requests are only issued while
// (buffered + in-flight) leaves room, counting a pop in the same cycle.
//
// Ports:
//   clk            clock
//   rstn           asynchronous active-low reset
//   o_ren          read request to the read pointer (combinational)
//   i_rempty       FIFO empty flag from the read pointer
//   i_ram_ren      RAM read accepted this cycle (data arrives next cycle)
//   i_ram_rdata    RAM read data
//   m_axis_tvalid  output word valid (registered)
//   m_axis_tready  downstream ready
//   m_axis_tdata   output word, buffer head (registered)
//   o_occupancy    words buffered, 0..2, excluding the in-flight word
// ---------------------------------------------------------------------------

// Simulation-only checker for buffer protocol violations.
module axis_fifo_rd_stage_chk (
    input logic       clk,
    input logic       rstn,
    input logic       push,
    input logic       pop,
    input logic [1:0] occupancy
);
    // Flag a push into a full buffer without a simultaneous pop, or an illegal count.
    always @(posedge clk) begin
        if (rstn) begin
            assert (!(push && !pop && (occupancy == 2'd2)))
                else $error("axis_fifo_rd_stage: push while buffer full");
            assert (occupancy != 2'd3)
                else $error("axis_fifo_rd_stage: illegal occupancy");
        end
    end
endmodule

module axis_fifo_rd_stage #(
    parameter int DLEN      = 8,
    parameter int BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rstn,
    output logic            o_ren,
    input  logic            i_rempty,
    input  logic            i_ram_ren,
    input  logic [DLEN-1:0] i_ram_rdata,
    output logic            m_axis_tvalid,
    input  logic            m_axis_tready,
    output logic [DLEN-1:0] m_axis_tdata,
    output logic [1:0]      o_occupancy
);

    generate
        if (BUF_DEPTH != 2) begin : g_bad_depth
            $error("axis_fifo_rd_stage: BUF_DEPTH must be 2");
        end
    endgenerate

    // State encoding equals the number of buffered words.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic            inflight_r;
    logic            tvalid_r;
    logic            tvalid_nxt_s;
    logic [DLEN-1:0] head_r;
    logic [DLEN-1:0] tail_r;
    logic [DLEN-1:0] head_nxt_s;
    logic [DLEN-1:0] tail_nxt_s;
    logic            push_s;
    logic            pop_s;
    logic [2:0]      credit_s;

    // RAM data is valid exactly one cycle after an accepted read.
    assign push_s = inflight_r;
    assign pop_s  = tvalid_r & m_axis_tready;

    // State, data and in-flight registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= ST_EMPTY;
            inflight_r <= 1'b0;
            tvalid_r   <= 1'b0;
            head_r     <= {DLEN{1'b0}};
            tail_r     <= {DLEN{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            inflight_r <= i_ram_ren;
            tvalid_r   <= tvalid_nxt_s;
            head_r     <= head_nxt_s;
            tail_r     <= tail_nxt_s;
        end
    end

    // Next-state and buffer data selection.
    always_comb begin
        state_nxt_s = state_r;
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        case (state_r)
            ST_EMPTY: begin
                if (push_s) begin
                    state_nxt_s = ST_ONE;
                    head_nxt_s  = i_ram_rdata;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                case ({push_s, pop_s})
                    2'b10: begin
                        state_nxt_s = ST_TWO;
                        tail_nxt_s  = i_ram_rdata;
                    end
                    2'b01: begin
                        state_nxt_s = ST_EMPTY;
                    end
                    2'b11: begin
                        state_nxt_s = ST_ONE;
                        head_nxt_s  = i_ram_rdata;
                    end
                    default: begin
                        state_nxt_s = ST_ONE;
                    end
                endcase
            end
            ST_TWO: begin
                if (pop_s) begin
                    head_nxt_s = tail_r;
                    if (push_s) begin
                        state_nxt_s = ST_TWO;
                        tail_nxt_s  = i_ram_rdata;
                    end else begin
                        state_nxt_s = ST_ONE;
                    end
                end else begin
                    // A push here cannot happen under the credit rule; the checker flags it.
                    state_nxt_s = ST_TWO;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
            end
        endcase
    end

    // Read request credit rule and registered-valid precompute.
    always_comb begin
        credit_s     = {1'b0, state_r} + {2'b00, inflight_r};
        // tready feeds o_ren combinationally so a pop frees a credit in the same cycle.
        o_ren        = ~i_rempty & ((credit_s < 3'd2) | pop_s);
        tvalid_nxt_s = (state_nxt_s != ST_EMPTY);
    end

    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tdata  = head_r;
    assign o_occupancy   = state_r;

    axis_fifo_rd_stage_chk u_chk (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push_s),
        .pop       (pop_s),
        .occupancy (o_occupancy)
    );

endmodule

// File: tb/tb_axis_fifo_rd_stage.sv
// ---------------------------------------------------------------------------
// tb_axis_fifo_rd_stage
// Directed bench for axis_fifo_rd_stage. A small read-pointer/RAM model
// supplies i_rempty, i_ram_ren and 1-cycle-latency i_ram_rdata.
// ---------------------------------------------------------------------------
module tb_axis_fifo_rd_stage;

    logic       clk = 1'b0;
    logic       rstn;
    logic       o_ren;
    logic       i_rempty;
    logic       i_ram_ren;
    logic [7:0] i_ram_rdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic [7:0] m_axis_tdata;
    logic [1:0] o_occupancy;

    logic [7:0] mem [0:255];
    logic [7:0] wptr;
    logic [7:0] rptr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    axis_fifo_rd_stage #(.DLEN(8), .BUF_DEPTH(2)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .o_ren         (o_ren),
        .i_rempty      (i_rempty),
        .i_ram_ren     (i_ram_ren),
        .i_ram_rdata   (i_ram_rdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .o_occupancy   (o_occupancy)
    );

    // Read pointer / RAM model: accepts o_ren when non-empty, data one cycle later.
    assign i_rempty  = (wptr == rptr);
    assign i_ram_ren = o_ren & ~i_rempty;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rptr        <= 8'd0;
            i_ram_rdata <= 8'd0;
        end else if (i_ram_ren) begin
            i_ram_rdata <= mem[rptr];
            rptr        <= rptr + 8'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] d);
        mem[wptr] = d;
        wptr      = wptr + 8'd1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
        check({tag, "_oren"},   32'(o_ren),         32'd0);
        check({tag, "_occ"},    32'(o_occupancy),   32'd0);
        check({tag, "_tdata"},  32'(m_axis_tdata),  32'd0);
    endtask

    initial begin
        int         idx;
        logic       prev_stall;
        logic [7:0] prev_data;

        // ---------------- 1: reset, FIFO empty ----------------
        wptr          = 8'd0;
        m_axis_tready = 1'b1;
        rstn          = 1'b1;
        #1 rstn       = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check_idle("t1_in_reset");
        end
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            check_idle("t1_idle");
        end

        // ---------------- 2: single word 0xA5 ----------------
        @(negedge clk);
        push_word(8'hA5);
        #1;
        check("t2_oren_N",    32'(o_ren),         32'd1);
        check("t2_tvalid_N",  32'(m_axis_tvalid), 32'd0);
        @(negedge clk); #1;
        check("t2_tvalid_N1", 32'(m_axis_tvalid), 32'd0);
        check("t2_oren_N1",   32'(o_ren),         32'd0);
        @(negedge clk); #1;
        check("t2_tvalid_N2", 32'(m_axis_tvalid), 32'd1);
        check("t2_tdata_N2",  32'(m_axis_tdata),  32'hA5);
        check("t2_occ_N2",    32'(o_occupancy),   32'd1);
        @(negedge clk); #1;
        check("t2_tvalid_N3", 32'(m_axis_tvalid), 32'd0);
        check("t2_occ_N3",    32'(o_occupancy),   32'd0);

        // ---------------- 3: 16 words, continuous tready ----------------
        @(negedge clk);
        for (int i = 0; i < 16; i++) push_word(8'(i));
        #1;
        check("t3_oren_N", 32'(o_ren), 32'd1);
        @(negedge clk); #1;
        check("t3_oren_N1", 32'(o_ren), 32'd1);
        check("t3_tvalid_N1", 32'(m_axis_tvalid), 32'd0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); #1;
            check("t3_tvalid", 32'(m_axis_tvalid), 32'd1);
            check("t3_tdata",  32'(m_axis_tdata),  32'(i));
        end
        @(negedge clk); #1;
        check("t3_drained", 32'(m_axis_tvalid), 32'd0);

        // ---------------- 4: backpressure saturation ----------------
        @(negedge clk);
        m_axis_tready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(8'(i));
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            check("t4_occ_sat",  32'(o_occupancy),   32'd2);
            check("t4_oren_sat", 32'(o_ren),         32'd0);
            check("t4_tvalid",   32'(m_axis_tvalid), 32'd1);
            check("t4_hold",     32'(m_axis_tdata),  32'h00);
        end
        @(negedge clk);
        m_axis_tready = 1'b1;
        #1;
        check("t4_oren_pop", 32'(o_ren),        32'd1);
        check("t4_data0",    32'(m_axis_tdata), 32'h00);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk); #1;
            check("t4_tvalid_drain", 32'(m_axis_tvalid), 32'd1);
            check("t4_data",         32'(m_axis_tdata),  32'(i));
        end
        @(negedge clk); #1;
        check("t4_done_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("t4_done_occ",    32'(o_occupancy),   32'd0);

        // ---------------- 5: stream with tready 1,0,0,1 ----------------
        @(negedge clk);
        for (int i = 0; i < 16; i++) push_word(8'h10 + 8'(i));
        idx        = 0;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        for (int c = 0; c < 200 && idx < 16; c++) begin
            @(negedge clk);
            m_axis_tready = ((c % 4) == 0) || ((c % 4) == 3);
            #1;
            if (prev_stall) begin
                check("t5_hold_valid", 32'(m_axis_tvalid), 32'd1);
                check("t5_hold_data",  32'(m_axis_tdata),  32'(prev_data));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                check("t5_order", 32'(m_axis_tdata), 32'h10 + 32'(idx));
                idx++;
            end
            prev_stall = m_axis_tvalid & ~m_axis_tready;
            prev_data  = m_axis_tdata;
        end
        check("t5_count", 32'(idx), 32'd16);
        m_axis_tready = 1'b1;
        @(negedge clk); #1;
        check("t5_drained", 32'(m_axis_tvalid), 32'd0);

        // ---------------- 6: async reset mid-stream ----------------
        @(negedge clk);
        m_axis_tready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(8'h20 + 8'(i));
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); #1;
        check("t6_pre_occ", 32'(o_occupancy), 32'd2);
        rstn          = 1'b0;
        wptr          = 8'd0;
        m_axis_tready = 1'b1;
        #1;
        check_idle("t6_reset");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        push_word(8'h55);
        #1;
        check("t6_oren_N",    32'(o_ren),         32'd1);
        @(negedge clk); #1;
        check("t6_tvalid_N1", 32'(m_axis_tvalid), 32'd0);
        @(negedge clk); #1;
        check("t6_tvalid_N2", 32'(m_axis_tvalid), 32'd1);
        check("t6_tdata_N2",  32'(m_axis_tdata),  32'h55);
        @(negedge clk); #1;
        check("t6_drained",   32'(m_axis_tvalid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
